// File: rtl/prio_code_decoder.sv
// prio_code_decoder
//   Turns 2-bit priority codes back into timed one-hot grants for three
//   sources. Codes are queued in a small FIFO. Each non-null code produces a
//   grant that is held for HOLD cycles. A break-before-make gap of two low
//   cycles (GAP + IDLE) follows every grant. A null code (2'b11) is consumed
//   in a single IDLE cycle and produces no grant.
//
//   Code map: 2'b10 -> 3'b100, 2'b01 -> 3'b010, 2'b00 -> 3'b001, 2'b11 -> none.
//
//   Handshake: a code is accepted on a rising clk edge when
//   code_valid && code_ready. code_ready is !full && rst_n. A full FIFO
//   refuses a push even when the same edge pops, so there is no full-bypass.
//   The producer must hold code_in stable while code_valid is high and
//   code_ready is low.
//
// Parameters
//   DEPTH  FIFO entries; must be a power of 2 and at least 2.
//   HOLD   cycles each grant stays asserted; legal range 1..255.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   code_in       priority code
//   code_valid    code_in is valid
//   code_ready    FIFO can accept a code
//   grant         registered one-hot grant; 3'b000 when idle
//   grant_active  registered OR of grant
//   busy          FSM not idle, or FIFO not empty
//   fifo_count    number of entries currently stored
//   null_cnt      saturating count of popped null codes. This port exists
//                 only when the PRIO_DEC_NULLCNT_EN macro is defined.
module prio_code_decoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               code_in,
  input  logic                     code_valid,
  output logic                     code_ready,
  output logic [2:0]               grant,
  output logic                     grant_active,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef PRIO_DEC_NULLCNT_EN
  ,
  output logic [7:0]               null_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  HOLD_M1  = 8'(HOLD - 1);
  localparam logic [1:0]  NULL_CODE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic [2:0]      grant_q, grant_d;
  logic            grant_active_q;

  logic [1:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;

  logic            full, empty, push, pop;
  logic [1:0]      head;
  logic            head_is_null;
  logic [2:0]      head_onehot;

  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign head         = mem_q[rd_ptr_q];
  assign head_is_null = (head == NULL_CODE);

  assign code_ready = rst_n && !full;
  assign push       = code_valid && code_ready;
  // The FIFO is only drained from IDLE, so a grant in progress never reads ahead.
  assign pop        = (state_q == S_IDLE) && !empty;

  always_comb begin
    head_onehot = 3'b000;
    case (head)
      2'b10:   head_onehot = 3'b100;
      2'b01:   head_onehot = 3'b010;
      2'b00:   head_onehot = 3'b001;
      default: head_onehot = 3'b000;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      hold_cnt_q     <= '0;
      grant_q        <= 3'b000;
      grant_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      grant_q        <= grant_d;
      grant_active_q <= |grant_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pop && !head_is_null) state_d = S_HOLD;
      S_HOLD: if (hold_cnt_q == '0)     state_d = S_GAP;
      S_GAP:                            state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (grant and hold counter) ----------------
  // The counter is loaded with HOLD-1 on the pop edge, because that edge
  // already produces the first grant cycle.
  always_comb begin
    grant_d    = grant_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        grant_d = 3'b000;
        if (pop && !head_is_null) begin
          grant_d    = head_onehot;
          hold_cnt_d = HOLD_M1;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - 8'd1;
        else                  grant_d    = 3'b000;
      end
      S_GAP:   grant_d = 3'b000;
      default: grant_d = 3'b000;
    endcase
  end

  assign grant        = grant_q;
  assign grant_active = grant_active_q;
  assign busy         = (state_q != S_IDLE) || !empty;

  // ---------------- FIFO ----------------
  // Storage is not reset. A reset clears count and pointers, so stale
  // entries are never read back.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= code_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign fifo_count = count_q;

`ifdef PRIO_DEC_NULLCNT_EN
  // ---------------- null-code counter ----------------
  logic [7:0] null_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      null_cnt_q <= '0;
    end else if (pop && head_is_null && (null_cnt_q != 8'hFF)) begin
      null_cnt_q <= null_cnt_q + 8'd1;
    end
  end

  assign null_cnt = null_cnt_q;
`endif

endmodule

// File: tb/tb_prio_code_decoder.sv
// Testbench for prio_code_decoder.
//   The reference model keeps a queue of the codes that are buffered. It also
//   keeps a timeline of the grant values expected on upcoming cycles. When a
//   non-null code is popped, the timeline gets the remaining HOLD-1 grant
//   cycles and then two low cycles. When the timeline is empty and a code is
//   queued, the model pops that code on the next edge.
module tb_prio_code_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 3;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    code_in;
  logic          code_valid;
  logic          code_ready;
  logic [2:0]    grant;
  logic          grant_active;
  logic          busy;
  logic [CW-1:0] fifo_count;
`ifdef PRIO_DEC_NULLCNT_EN
  logic [7:0]    null_cnt;
`endif

  prio_code_decoder #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .grant        (grant),
    .grant_active (grant_active),
    .busy         (busy),
    .fifo_count   (fifo_count)
`ifdef PRIO_DEC_NULLCNT_EN
    ,
    .null_cnt     (null_cnt)
`endif
  );

  // ---------------- reference model state ----------------
  logic [1:0] code_q[$];       // buffered codes, head at index 0
  logic [2:0] exp_q[$];        // expected grant on upcoming cycles
  logic [2:0] exp_grant = 3'b000;
  int         exp_null  = 0;
  logic       last_accept;

  int vectors    = 0;
  int miscompares = 0;

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // This task applies the inputs and checks code_ready before the edge.
  // It then advances the model across the edge and checks the registered
  // outputs 1 time unit later.
  task automatic step(input logic rst, input logic v, input logic [1:0] c);
    logic       exp_ready;
    logic [1:0] hc;
    rst_n = rst; code_valid = v; code_in = c;
    #1;
    exp_ready = rst && (code_q.size() < DEPTH);
    chk("code_ready", code_ready, exp_ready);
    last_accept = v && exp_ready;
    @(posedge clk);
    if (!rst) begin
      code_q.delete();
      exp_q.delete();
      exp_grant = 3'b000;
      exp_null  = 0;
    end else begin
      if (exp_q.size() > 0) begin
        exp_grant = exp_q.pop_front();
      end else if (code_q.size() > 0) begin
        hc = code_q.pop_front();
        if (hc == 2'b11) begin
          exp_grant = 3'b000;
          if (exp_null < 255) exp_null++;
        end else begin
          exp_grant = 3'b001 << hc;
          for (int i = 0; i < int'(HOLD) - 1; i++) exp_q.push_back(exp_grant);
          exp_q.push_back(3'b000);
          exp_q.push_back(3'b000);
        end
      end else begin
        exp_grant = 3'b000;
      end
      if (last_accept) code_q.push_back(c);
    end
    #1;
    chk("grant", grant, exp_grant);
    chk("grant_active", grant_active, |exp_grant);
    chk("grant_onehot0", $onehot0(grant), 1);
    chk("fifo_count", fifo_count, code_q.size());
    chk("busy", busy, (exp_q.size() > 0) || (code_q.size() > 0));
`ifdef PRIO_DEC_NULLCNT_EN
    chk("null_cnt", null_cnt, exp_null);
`endif
  endtask

  // Push one code. The code is held stable until it is accepted, and the
  // number of attempts is bounded.
  task automatic push_code(input logic [1:0] c);
    int tries = 0;
    do begin
      step(1'b1, 1'b1, c);
      tries++;
    end while (!last_accept && tries < 64);
    chk("push_accepted", last_accept, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n = 1'b0; code_valid = 1'b0; code_in = 2'b00;

    // Reset with code_valid held high. Release to an idle block.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b10);
    idle(2);

    // Single grant into an idle block, then drain.
    push_code(2'b10);
    idle(8);

    // Back-to-back different sources.
    push_code(2'b00);
    push_code(2'b01);
    push_code(2'b10);
    idle(20);

    // Fill past DEPTH while the first grant is held. This exercises the
    // backpressure and the pointer wrap.
    push_code(2'b01);
    push_code(2'b00);
    push_code(2'b10);
    push_code(2'b01);
    push_code(2'b00);
    push_code(2'b10);
    idle(40);

    // Null codes followed by a real one.
    push_code(2'b11);
    push_code(2'b11);
    push_code(2'b01);
    idle(10);

    // Enough nulls to saturate the null counter.
    for (int i = 0; i < 300; i++) push_code(2'b11);
    idle(6);

    // Reset mid-HOLD with codes queued.
    push_code(2'b10);
    push_code(2'b01);
    push_code(2'b00);
    push_code(2'b10);
    step(1'b0, 1'b0, 2'b00);
    idle(10);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)));
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
